alu_rs: RTL

- Reservation station feeding the integer ALU in the Tomasulo core.
- Accepts decoded ALU-class instructions from dispatch into RS_SIZE entries.
- Snoops the ALU and LSB broadcast buses to capture pending operands.
- Issues one ready entry per cycle to the ALU via a registered new_calculate/op/vj/vk/pc/imm/instruction/entry bundle; the ALU answers next cycle on its broadcast bus.

---
 rtl/alu_rs_if.sv | 51 +++++
 rtl/alu_rs.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// Dispatch/snoop/issue signal bundle for the ALU reservation station.
// issue_valid is a one-cycle write strobe with no back-pressure: dispatch must keep it low while rs_full is high.
interface alu_rs_if #(
    parameter int ENTRY_W = 4
);
    logic               rdy_in;
    logic               rollback;
    logic               issue_valid;
    logic [5:0]         issue_op;
    logic [31:0]        issue_instruction;
    logic [31:0]        issue_pc;
    logic [31:0]        issue_imm;
    logic [ENTRY_W-1:0] issue_entry;
    logic               issue_qj_busy;
    logic               issue_qk_busy;
    logic [ENTRY_W-1:0] issue_qj;
    logic [ENTRY_W-1:0] issue_qk;
    logic [31:0]        issue_vj;
    logic [31:0]        issue_vk;
    logic               alu_broadcast;
    logic [ENTRY_W-1:0] alu_entry;
    logic [31:0]        alu_result;
    logic               lsb_broadcast;
    logic [ENTRY_W-1:0] lsb_entry;
    logic [31:0]        lsb_result;
    logic               rs_full;
    logic               new_calculate;
    logic [5:0]         op;
    logic [31:0]        instruction;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [ENTRY_W-1:0] entry;

    modport master (
        output rdy_in, rollback, issue_valid, issue_op, issue_instruction, issue_pc,
               issue_imm, issue_entry, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
               issue_vj, issue_vk, alu_broadcast, alu_entry, alu_result,
               lsb_broadcast, lsb_entry, lsb_result,
        input  rs_full, new_calculate, op, instruction, vj, vk, pc, imm, entry
    );

    modport slave (
        input  rdy_in, rollback, issue_valid, issue_op, issue_instruction, issue_pc,
               issue_imm, issue_entry, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
               issue_vj, issue_vk, alu_broadcast, alu_entry, alu_result,
               lsb_broadcast, lsb_entry, lsb_result,
        output rs_full, new_calculate, op, instruction, vj, vk, pc, imm, entry
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: captures operands from both CDBs and issues one ready entry per cycle.
// Optional ALU_RS_OLDEST_FIRST_EN: per-entry saturating age, select oldest ready entry instead of lowest index.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int ENTRY_W = 4
) (
    input  logic    clk_in,
    input  logic    rst_in,
    alu_rs_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [5:0]         r_op    [RS_SIZE];
    logic [31:0]        r_instr [RS_SIZE];
    logic [31:0]        r_pc    [RS_SIZE];
    logic [31:0]        r_imm   [RS_SIZE];
    logic [31:0]        r_vj    [RS_SIZE];
    logic [31:0]        r_vk    [RS_SIZE];
    logic [ENTRY_W-1:0] r_dest  [RS_SIZE];
    logic [ENTRY_W-1:0] r_qj    [RS_SIZE];
    logic [ENTRY_W-1:0] r_qk    [RS_SIZE];
`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [7:0]         r_age   [RS_SIZE];
    logic [7:0]         w_best_age;
`endif

    logic               r_new_calculate;
    logic [5:0]         r_out_op;
    logic [31:0]        r_out_instr;
    logic [31:0]        r_out_vj;
    logic [31:0]        r_out_vk;
    logic [31:0]        r_out_pc;
    logic [31:0]        r_out_imm;
    logic [ENTRY_W-1:0] r_out_entry;

    logic               w_alu_bc;
    logic [ENTRY_W-1:0] w_alu_tag;
    logic [31:0]        w_alu_val;
    logic               w_lsb_bc;
    logic [ENTRY_W-1:0] w_lsb_tag;
    logic [31:0]        w_lsb_val;

    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_qj_pend;
    logic [RS_SIZE-1:0] w_qk_pend;
    logic [31:0]        w_vj_next [RS_SIZE];
    logic [31:0]        w_vk_next [RS_SIZE];
    logic               w_ins_qj_pend;
    logic               w_ins_qk_pend;
    logic [31:0]        w_ins_vj;
    logic [31:0]        w_ins_vk;
    logic               w_any_ready;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any_free;
    logic [IDX_W-1:0]   w_free_idx;

    assign w_alu_bc  = bus.alu_broadcast;
    assign w_alu_tag = bus.alu_entry;
    assign w_alu_val = bus.alu_result;
    assign w_lsb_bc  = bus.lsb_broadcast;
    assign w_lsb_tag = bus.lsb_entry;
    assign w_lsb_val = bus.lsb_result;

    assign bus.rs_full       = &r_busy;
    assign bus.new_calculate = r_new_calculate;
    assign bus.op            = r_out_op;
    assign bus.instruction   = r_out_instr;
    assign bus.vj            = r_out_vj;
    assign bus.vk            = r_out_vk;
    assign bus.pc            = r_out_pc;
    assign bus.imm           = r_out_imm;
    assign bus.entry         = r_out_entry;

    // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
    function automatic logic [32:0] snoop(input logic pend, input logic [ENTRY_W-1:0] tag,
                                          input logic [31:0] val);
        if (!pend)
            return {1'b0, val};
        if (w_alu_bc && (w_alu_tag == tag))
            return {1'b0, w_alu_val};
        if (w_lsb_bc && (w_lsb_tag == tag))
            return {1'b0, w_lsb_val};
        return {1'b1, val};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {w_qj_pend[i], w_vj_next[i]} = snoop(r_qj_busy[i], r_qj[i], r_vj[i]);
            {w_qk_pend[i], w_vk_next[i]} = snoop(r_qk_busy[i], r_qk[i], r_vk[i]);
        end
        {w_ins_qj_pend, w_ins_vj} = snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
        {w_ins_qk_pend, w_ins_vk} = snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
    end

    // Readiness uses cycle-start state, so a wake-up is selectable one cycle later.
    assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;

    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    always_comb begin
        w_any_ready = 1'b0;
        w_sel_idx   = '0;
        w_best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_ready[i] && (!w_any_ready || (r_age[i] > w_best_age))) begin
                w_any_ready = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_best_age  = r_age[i];
            end
        end
    end
`else
    always_comb begin
        w_any_ready = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_any_ready = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy          <= '0;
            r_qj_busy       <= '0;
            r_qk_busy       <= '0;
            r_new_calculate <= 1'b0;
            r_out_op        <= '0;
            r_out_instr     <= '0;
            r_out_vj        <= '0;
            r_out_vk        <= '0;
            r_out_pc        <= '0;
            r_out_imm       <= '0;
            r_out_entry     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]    <= '0;
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
                r_imm[i]   <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_dest[i]  <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
                r_age[i]   <= '0;
`endif
            end
        end else if (!bus.rdy_in) begin
            r_new_calculate <= 1'b0;
        end else if (bus.rollback) begin
            r_busy          <= '0;
            r_new_calculate <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_qj_busy[i] <= w_qj_pend[i];
                    r_qk_busy[i] <= w_qk_pend[i];
                    r_vj[i]      <= w_vj_next[i];
                    r_vk[i]      <= w_vk_next[i];
                end
            end

            r_new_calculate <= w_any_ready;
            if (w_any_ready) begin
                r_out_op            <= r_op[w_sel_idx];
                r_out_instr         <= r_instr[w_sel_idx];
                r_out_vj            <= r_vj[w_sel_idx];
                r_out_vk            <= r_vk[w_sel_idx];
                r_out_pc            <= r_pc[w_sel_idx];
                r_out_imm           <= r_imm[w_sel_idx];
                r_out_entry         <= r_dest[w_sel_idx];
                r_busy[w_sel_idx]   <= 1'b0;
            end

            // The free slot comes from cycle-start busy bits, so it never collides with the issuing slot.
            if (bus.issue_valid && w_any_free) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= bus.issue_op;
                r_instr[w_free_idx]   <= bus.issue_instruction;
                r_pc[w_free_idx]      <= bus.issue_pc;
                r_imm[w_free_idx]     <= bus.issue_imm;
                r_dest[w_free_idx]    <= bus.issue_entry;
                r_qj[w_free_idx]      <= bus.issue_qj;
                r_qk[w_free_idx]      <= bus.issue_qk;
                r_qj_busy[w_free_idx] <= w_ins_qj_pend;
                r_qk_busy[w_free_idx] <= w_ins_qk_pend;
                r_vj[w_free_idx]      <= w_ins_vj;
                r_vk[w_free_idx]      <= w_ins_vk;
`ifdef ALU_RS_OLDEST_FIRST_EN
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && (r_age[i] != 8'hFF))
                        r_age[i] <= r_age[i] + 8'd1;
                end
                r_age[w_free_idx]     <= '0;
`endif
            end
        end
    end
endmodule
